// File: rtl/dnn_stream_host.sv
// Host-side stream endpoint: feeds the accelerator src stream from a 128-bit SRAM and
// drains its dst stream into a 64-bit SRAM. Optional stall counters: DNN_STREAM_PERF_EN.
module dnn_stream_host #(
  parameter int unsigned AW = 12,
  parameter int unsigned LW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] src_base,
  input  logic [LW-1:0] src_len,
  input  logic [AW-1:0] dst_base,
  input  logic [LW-1:0] dst_len,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [LW-1:0] dst_cnt,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [127:0]  rd_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [63:0]   wr_data,
  output logic          src_valid,
  output logic [31:0]   src_data0,
  output logic [31:0]   src_data1,
  output logic [31:0]   src_data2,
  output logic [31:0]   src_data3,
  output logic          src_last,
  input  logic          src_ready,
  input  logic          dst_valid,
  input  logic [31:0]   dst_data0,
  input  logic [31:0]   dst_data1,
  input  logic          dst_last,
`ifdef DNN_STREAM_PERF_EN
  output logic [LW-1:0] stall_src,
  output logic [LW-1:0] stall_dst,
`endif
  output logic          dst_ready
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] src_base_q, dst_base_q;
  logic [LW-1:0] src_len_q, dst_len_q;
  logic [LW-1:0] issued_q, popped_q, dst_cnt_q;
  logic          pend_q;
  logic [127:0]  fifo_q [2];
  logic [1:0]    fifo_cnt_q;
  logic          rd_ptr_q, wr_ptr_q;
  logic          sink_done_q, err_q;

  logic          start_job, pop, accept, room, src_done, issue_ok;
  logic [1:0]    occ;
  logic [127:0]  head;

  assign start_job = (state_q == IDLE) && start;
  assign src_valid = (fifo_cnt_q != 2'd0);
  assign pop       = src_valid && src_ready;
  assign accept    = dst_valid && dst_ready;
  assign room      = (dst_cnt_q < dst_len_q);
  assign src_done  = (popped_q == src_len_q);
  // Occupancy after this cycle's pop, so a draining head frees its slot for a new read.
  assign occ       = fifo_cnt_q + 2'(pend_q) - 2'(pop);
  assign issue_ok  = (issued_q != src_len_q) && (occ < 2'd2);

  assign head      = src_valid ? fifo_q[rd_ptr_q] : '0;
  assign src_data0 = head[31:0];
  assign src_data1 = head[63:32];
  assign src_data2 = head[95:64];
  assign src_data3 = head[127:96];
  assign src_last  = src_valid && (popped_q == (src_len_q - LW'(1)));
  assign rd_addr   = rd_en ? (src_base_q + AW'(issued_q)) : '0;
  assign err       = err_q;
  assign dst_cnt   = dst_cnt_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and strobes
  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    rd_en     = 1'b0;
    dst_ready = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        busy      = 1'b1;
        rd_en     = issue_ok;
        dst_ready = !sink_done_q;
        wr_en     = dst_valid && !sink_done_q && room;
        if (src_done && sink_done_q) state_d = FLUSH;
      end
      FLUSH: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (wr_en) begin
      wr_addr = dst_base_q + AW'(dst_cnt_q);
      wr_data = {dst_data1, dst_data0};
    end
  end

  // Job datapath: prefetch FIFO, beat counters, sink bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_base_q  <= '0;
      dst_base_q  <= '0;
      src_len_q   <= '0;
      dst_len_q   <= '0;
      issued_q    <= '0;
      popped_q    <= '0;
      dst_cnt_q   <= '0;
      pend_q      <= 1'b0;
      fifo_q[0]   <= '0;
      fifo_q[1]   <= '0;
      fifo_cnt_q  <= '0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      sink_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else if (start_job) begin
      src_base_q  <= src_base;
      dst_base_q  <= dst_base;
      src_len_q   <= src_len;
      dst_len_q   <= dst_len;
      issued_q    <= '0;
      popped_q    <= '0;
      dst_cnt_q   <= '0;
      pend_q      <= 1'b0;
      fifo_cnt_q  <= '0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      sink_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      pend_q <= rd_en;
      if (rd_en) issued_q <= issued_q + LW'(1);
      if (pend_q) begin
        fifo_q[wr_ptr_q] <= rd_data;
        wr_ptr_q         <= !wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= !rd_ptr_q;
        popped_q <= popped_q + LW'(1);
      end
      fifo_cnt_q <= fifo_cnt_q + 2'(pend_q) - 2'(pop);
      if (accept) begin
        if (dst_cnt_q != '1) dst_cnt_q <= dst_cnt_q + LW'(1);
        if (!room) err_q <= 1'b1;
        if (dst_last) begin
          sink_done_q <= 1'b1;
          // Sink finished while src beats remain (a same-cycle final pop counts as drained)
          if ((popped_q + LW'(pop)) != src_len_q) err_q <= 1'b1;
        end
      end
    end
  end

`ifdef DNN_STREAM_PERF_EN
  logic [LW-1:0] stall_src_q, stall_dst_q;
  assign stall_src = stall_src_q;
  assign stall_dst = stall_dst_q;

  // Saturating stall counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_src_q <= '0;
      stall_dst_q <= '0;
    end else if (start_job) begin
      stall_src_q <= '0;
      stall_dst_q <= '0;
    end else if (state_q == RUN) begin
      if (src_valid && !src_ready && (stall_src_q != '1))
        stall_src_q <= stall_src_q + LW'(1);
      if (dst_ready && !dst_valid && src_done && (stall_dst_q != '1))
        stall_dst_q <= stall_dst_q + LW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_dnn_stream_host.sv
// Self-checking bench for dnn_stream_host: directed job table, random jobs against a
// stream-level reference model, and a reset-mid-job sequence.
module tb_dnn_stream_host;

  localparam int unsigned AW = 12;
  localparam int unsigned LW = 12;
  localparam int BUDGET = 600;

  logic          clk, rst_n, start;
  logic [AW-1:0] src_base, dst_base;
  logic [LW-1:0] src_len, dst_len;
  logic          busy, done, err;
  logic [LW-1:0] dst_cnt;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [127:0]  rd_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [63:0]   wr_data;
  logic          src_valid, src_last, src_ready;
  logic [31:0]   src_data0, src_data1, src_data2, src_data3;
  logic          dst_valid, dst_last, dst_ready;
  logic [31:0]   dst_data0, dst_data1;
`ifdef DNN_STREAM_PERF_EN
  logic [LW-1:0] stall_src, stall_dst;
`endif

  dnn_stream_host #(.AW(AW), .LW(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .src_base(src_base), .src_len(src_len), .dst_base(dst_base), .dst_len(dst_len),
    .busy(busy), .done(done), .err(err), .dst_cnt(dst_cnt),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .src_valid(src_valid), .src_data0(src_data0), .src_data1(src_data1),
    .src_data2(src_data2), .src_data3(src_data3), .src_last(src_last), .src_ready(src_ready),
    .dst_valid(dst_valid), .dst_data0(dst_data0), .dst_data1(dst_data1), .dst_last(dst_last),
`ifdef DNN_STREAM_PERF_EN
    .stall_src(stall_src), .stall_dst(stall_dst),
`endif
    .dst_ready(dst_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read SRAM model: data valid exactly one cycle after rd_en, garbage otherwise
  logic [127:0] smem [0:4095];
  logic         rq;
  logic [AW-1:0] ra;
  always @(negedge clk) begin
    rq = rd_en;
    ra = rd_addr;
  end
  always @(posedge clk)
    rd_data <= rq ? smem[ra] : {$urandom, $urandom, $urandom, $urandom};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic int outs_nz();
    return int'(busy | done | err | (|dst_cnt) | rd_en | (|rd_addr) | wr_en | (|wr_addr) |
                (|wr_data) | src_valid | (|src_data0) | (|src_data1) | (|src_data2) |
                (|src_data3) | src_last | dst_ready);
  endfunction

  typedef struct {
    logic [AW-1:0] sb;
    logic [LW-1:0] sl;
    logic [AW-1:0] db;
    logic [LW-1:0] dl;
    int            nd;      // dst beats the accelerator returns
    int            smode;   // 0: ready=1, 1: 1,0,0,1 pattern, 2: random (also random dst_valid)
    bit            early;   // allow dst_last before the src side drains
    bit            poke;    // pulse start mid-run and during the done cycle
    int            exp_err; // -1: derive from the reference model
    logic [LW-1:0] exp_cnt;
    int            exp_nwr;
  } vec_t;

  function automatic logic ready_bit(input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (mode == 1) return ((k % 4) == 1) || ((k % 4) == 0);
    return 1'($urandom % 2);
  endfunction

  task automatic run_job(input vec_t v);
    logic [63:0]   dd [$];
    logic [128:0]  got_src [$];
    logic [AW-1:0] got_rd [$];
    logic [75:0]   got_wr [$];
    logic [128:0]  cur, held, exp_beat;
    logic [AW-1:0] a;
    int j, n_rd, n_pop, n_done, k, fv, last_pop_k, done_k, max_out, stab_bad, bad, nwr_exp, e_err;
    bit early_obs, stalled, fin;
    j = 0; n_rd = 0; n_pop = 0; n_done = 0; fv = -1; last_pop_k = -1; done_k = -1;
    max_out = 0; stab_bad = 0; early_obs = 0; stalled = 0; fin = 0; held = '0;
    for (int i = 0; i < v.nd; i++) dd.push_back({$urandom, $urandom});
    // start cycle (caller leaves us at posedge+1)
    src_base = v.sb; src_len = v.sl; dst_base = v.db; dst_len = v.dl;
    start = 1'b1; src_ready = 1'b0; dst_valid = 1'b0; dst_last = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    // latched values must not follow the inputs after start
    src_base = AW'($urandom); src_len = LW'($urandom); dst_base = AW'($urandom); dst_len = LW'($urandom);
    k = 1;
    while (!fin && k < BUDGET) begin
      src_ready = ready_bit(v.smode, k);
      if (j < v.nd && (v.early || j != v.nd - 1 || n_pop >= int'(v.sl)) &&
          (v.smode != 2 || ($urandom % 4) != 0)) begin
        dst_valid = 1'b1;
        {dst_data1, dst_data0} = dd[j];
        dst_last = (j == v.nd - 1);
      end else begin
        dst_valid = 1'b0;
        dst_last  = 1'b0;
      end
      start = v.poke && ((k == 3) || done);
      @(negedge clk);
      cur = {src_last, src_data3, src_data2, src_data1, src_data0};
      if (src_valid && fv < 0) fv = k;
      if (stalled && (!src_valid || cur != held)) stab_bad++;
      stalled = src_valid && !src_ready;
      held = cur;
      if (rd_en) begin n_rd++; got_rd.push_back(rd_addr); end
      if (src_valid && src_ready) begin got_src.push_back(cur); n_pop++; last_pop_k = k; end
      if (wr_en) got_wr.push_back({wr_addr, wr_data});
      if (dst_valid && dst_ready) begin
        if (dst_last && n_pop < int'(v.sl)) early_obs = 1;
        j++;
      end
      if (n_rd - n_pop > max_out) max_out = n_rd - n_pop;
      if (done) begin n_done++; if (done_k < 0) done_k = k; end
      if (done_k >= 0 && k >= done_k + 2) fin = 1;
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0; dst_valid = 1'b0; dst_last = 1'b0; src_ready = 1'b0;

    chk("done_seen", 64'(done_k >= 0), 64'd1);
    chk("done_pulses", 64'(n_done), 64'd1);
    chk("busy_after", 64'(busy), 64'd0);
    chk("src_beats", 64'(got_src.size()), 64'(v.sl));
    bad = 0;
    for (int i = 0; i < got_src.size() && i < int'(v.sl); i++) begin
      a = v.sb + AW'(i);
      exp_beat = {(i == int'(v.sl) - 1), smem[a]};
      if (got_src[i] !== exp_beat) bad++;
    end
    chk("src_data_last", 64'(bad), 64'd0);
    chk("rd_count", 64'(n_rd), 64'(v.sl));
    bad = 0;
    for (int i = 0; i < got_rd.size(); i++)
      if (got_rd[i] !== v.sb + AW'(i)) bad++;
    chk("rd_addr_seq", 64'(bad), 64'd0);
    chk("outstanding_le2", 64'(max_out > 2), 64'd0);
    chk("stall_hold", 64'(stab_bad), 64'd0);
    nwr_exp = (v.nd < int'(v.dl)) ? v.nd : int'(v.dl);
    chk("wr_count", 64'(got_wr.size()), 64'(v.exp_nwr));
    bad = 0;
    for (int i = 0; i < got_wr.size() && i < nwr_exp; i++)
      if (got_wr[i] !== {v.db + AW'(i), dd[i]}) bad++;
    chk("wr_addr_data", 64'(bad), 64'd0);
    chk("dst_cnt", 64'(dst_cnt), 64'(v.exp_cnt));
    e_err = (v.exp_err < 0) ? int'((v.nd > int'(v.dl)) || early_obs) : v.exp_err;
    chk("err", 64'(err), 64'(e_err));
    if (v.sl != 0) begin
      chk("first_valid_lat", 64'(fv - 1), 64'd2);
      chk("done_after_pop", 64'(done_k > last_pop_k), 64'd1);
    end
  endtask

  vec_t tbl [7];
  vec_t rv;

  initial begin
    int n_pop, k;
    for (int i = 0; i < 4096; i++) smem[i] = {$urandom, $urandom, $urandom, $urandom};
    //        sb       sl  db       dl  nd smode early poke err cnt nwr
    tbl[0] = '{12'h010, 3, 12'h100, 4, 2, 0, 0, 0, 0, 12'd2, 2};  // basic
    tbl[1] = '{12'h020, 4, 12'h200, 4, 2, 1, 0, 1, 0, 12'd2, 2};  // backpressure, start ignored
    tbl[2] = '{12'h030, 2, 12'h300, 1, 3, 0, 0, 0, 1, 12'd3, 1};  // overflow
    tbl[3] = '{12'h040, 0, 12'h400, 2, 1, 0, 0, 0, 0, 12'd1, 1};  // zero length
    tbl[4] = '{12'h050, 3, 12'h500, 4, 1, 1, 1, 0, 1, 12'd1, 1};  // early last
    tbl[5] = '{12'hFFE, 4, 12'hFFF, 3, 3, 0, 0, 0, 0, 12'd3, 3};  // address wrap
    tbl[6] = '{12'h060, 1, 12'h600, 0, 2, 0, 0, 0, 1, 12'd2, 0};  // zero capacity

    rst_n = 1'b0; start = 1'b0; src_base = '0; src_len = '0; dst_base = '0; dst_len = '0;
    src_ready = 1'b0; dst_valid = 1'b0; dst_last = 1'b0; dst_data0 = '0; dst_data1 = '0;
    repeat (3) @(posedge clk);
    #1 chk("reset_outputs", 64'(outs_nz()), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_job(tbl[i]);

    // Reset during beat 2 of a 5-beat job
    src_base = 12'h070; src_len = 5; dst_base = 12'h700; dst_len = 4;
    start = 1'b1; src_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_pop = 0; k = 0;
    while (n_pop < 2 && k < 50) begin
      @(negedge clk);
      if (src_valid && src_ready) n_pop++;
      @(posedge clk); #1;
      k++;
    end
    chk("rst_reached_beat2", 64'(n_pop), 64'd2);
    chk("rst_beat2_valid", 64'(src_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1 chk("rst_async_outputs", 64'(outs_nz()), 64'd0);
    k = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) k++;
    end
    chk("rst_no_done", 64'(k), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_job(tbl[0]);

    // Random jobs checked against the stream-level model
    for (int r = 0; r < 20; r++) begin
      rv.sb = AW'($urandom); rv.sl = LW'($urandom_range(0, 8));
      rv.db = AW'($urandom); rv.dl = LW'($urandom_range(0, 6));
      rv.nd = $urandom_range(1, 6); rv.smode = 2; rv.early = 1'($urandom % 2);
      rv.poke = 1'($urandom % 2); rv.exp_err = -1;
      rv.exp_cnt = LW'(rv.nd);
      rv.exp_nwr = (rv.nd < int'(rv.dl)) ? rv.nd : int'(rv.dl);
      run_job(rv);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
